// File: rtl/gcd_job_scheduler.sv
// Round-robin scheduler sharing one subtractive GCD core among N_REQ requesters.
// Zero operands bypass the core; a WAIT timeout resets a hung core and returns an error.
module gcd_job_scheduler #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ID_W    = 2,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ*DATA_W-1:0] req_a,
   input  logic [N_REQ*DATA_W-1:0] req_b,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [ID_W-1:0]         resp_id,
   output logic [DATA_W-1:0]       resp_data,
   output logic                    resp_err,
   output logic                    core_start,
   output logic [DATA_W-1:0]       core_a,
   output logic [DATA_W-1:0]       core_b,
   input  logic                    core_done,
   input  logic [DATA_W-1:0]       core_result,
   output logic                    core_rst_n,
   output logic                    busy
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned SUM_W = ID_W + 1;

   typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_ABORT, S_RESP} state_t;

   state_t              state_q;
   logic [ID_W-1:0]     rr_q;
   logic [CNT_W-1:0]    cnt_q;

   logic [2*N_REQ-1:0]  dbl_c;
   logic [N_REQ-1:0]    rot_c;
   logic [ID_W-1:0]     off_c;
   logic [SUM_W-1:0]    sum_c;
   logic [ID_W-1:0]     win_id_c;
   logic [ID_W-1:0]     rr_next_c;
   logic [DATA_W-1:0]   win_a_c;
   logic [DATA_W-1:0]   win_b_c;
   logic                grant_c;

   // Rotate valids so rr_q sits at bit 0; the lowest set bit is the winner's offset.
   always_comb begin
      dbl_c = {req_valid, req_valid} >> rr_q;
      rot_c = dbl_c[N_REQ-1:0];
      off_c = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot_c[k]) off_c = ID_W'(k);
      end
      sum_c    = SUM_W'(rr_q) + SUM_W'(off_c);
      win_id_c = (sum_c >= SUM_W'(N_REQ)) ? ID_W'(sum_c - SUM_W'(N_REQ)) : ID_W'(sum_c);
      rr_next_c = (win_id_c == ID_W'(N_REQ - 1)) ? '0 : win_id_c + ID_W'(1);
   end

   always_comb begin
      win_a_c = '0;
      win_b_c = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (win_id_c == ID_W'(k)) begin
            win_a_c = req_a[k*DATA_W +: DATA_W];
            win_b_c = req_b[k*DATA_W +: DATA_W];
         end
      end
   end

   assign grant_c   = (state_q == S_IDLE) && (|req_valid);
   assign req_ready = grant_c ? (N_REQ'(1) << win_id_c) : '0;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= S_IDLE;
         rr_q       <= '0;
         cnt_q      <= '0;
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_data  <= '0;
         resp_err   <= 1'b0;
         core_start <= 1'b0;
         core_a     <= '0;
         core_b     <= '0;
         core_rst_n <= 1'b0;
         busy       <= 1'b0;
      end else begin
         core_start <= 1'b0;
         core_rst_n <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (grant_c) begin
                  resp_id <= win_id_c;
                  rr_q    <= rr_next_c;
                  busy    <= 1'b1;
                  // The subtractive core never terminates on a zero operand.
                  if ((win_a_c == '0) || (win_b_c == '0)) begin
                     resp_data  <= win_a_c | win_b_c;
                     resp_err   <= 1'b0;
                     resp_valid <= 1'b1;
                     state_q    <= S_RESP;
                  end else begin
                     core_a     <= win_a_c;
                     core_b     <= win_b_c;
                     core_start <= 1'b1;
                     state_q    <= S_LAUNCH;
                  end
               end
            end
            S_LAUNCH: begin
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (core_done) begin
                  resp_data  <= core_result;
                  resp_err   <= 1'b0;
                  resp_valid <= 1'b1;
                  state_q    <= S_RESP;
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  core_rst_n <= 1'b0;
                  state_q    <= S_ABORT;
               end
            end
            S_ABORT: begin
               resp_data  <= '0;
               resp_err   <= 1'b1;
               resp_valid <= 1'b1;
               state_q    <= S_RESP;
            end
            S_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  busy       <= 1'b0;
                  state_q    <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_job_scheduler.sv
// Randomized scoreboard bench for gcd_job_scheduler: a requester driver, a behavioural
// GCD core, and a negedge monitor comparing responses against a round-robin/Euclid model.
module tb_gcd_job_scheduler;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned IW = 2;
   localparam int unsigned TO = 16;

   typedef struct { int id; logic [DW-1:0] a; logic [DW-1:0] b; int unsigned lat; } job_t;
   typedef struct { int id; logic [DW-1:0] data; logic err; int unsigned cyc; } resp_t;
   typedef struct { logic [DW-1:0] a; logic [DW-1:0] b; int unsigned lat; int unsigned cyc; } core_t;

   logic              sys_clk;
   logic              sys_rst_n;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*DW-1:0]   req_a;
   logic [N*DW-1:0]   req_b;
   logic              resp_valid;
   logic              resp_ready;
   logic [IW-1:0]     resp_id;
   logic [DW-1:0]     resp_data;
   logic              resp_err;
   logic              core_start;
   logic [DW-1:0]     core_a;
   logic [DW-1:0]     core_b;
   logic              core_done;
   logic [DW-1:0]     core_result;
   logic              core_rst_n;
   logic              busy;

   gcd_job_scheduler #(.N_REQ(N), .DATA_W(DW), .ID_W(IW), .TIMEOUT(TO)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_data(resp_data), .resp_err(resp_err),
      .core_start(core_start), .core_a(core_a), .core_b(core_b),
      .core_done(core_done), .core_result(core_result), .core_rst_n(core_rst_n),
      .busy(busy)
   );

   int unsigned   cyc = 0;
   int            n_cmp = 0;
   int            n_bad = 0;
   job_t          jobs[$];
   resp_t         exp_q[$];
   core_t         core_q[$];
   int unsigned   abort_q[$];
   int            gl[$];
   logic [DW-1:0] cur_a[N];
   logic [DW-1:0] cur_b[N];
   int unsigned   cur_lat[N];
   logic [N-1:0]  granted = '0;
   int            model_rr = 0;
   bit            chk_en = 1'b0;
   bit            core_pend = 1'b0;
   int unsigned   done_at = 0;
   logic [DW-1:0] core_res = '0;
   bit            bp_low = 1'b0;
   bit            rnd_ready = 1'b0;
   int            n_start = 0;
   int            n_start_exp = 0;

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] gcd(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW-1:0] x;
      logic [DW-1:0] y;
      logic [DW-1:0] t;
      x = a;
      y = b;
      while (y != '0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   task automatic post(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input int unsigned lat);
      job_t j;
      j.id = id; j.a = a; j.b = b; j.lat = lat;
      jobs.push_back(j);
   endtask

   task automatic wait_drain(input int unsigned budget);
      int unsigned n;
      n = 0;
      while ((jobs.size() != 0 || req_valid != '0 || exp_q.size() != 0 || resp_valid
              || core_pend) && n < budget) begin
         @(negedge sys_clk); #2;
         n++;
      end
      if (n >= budget) chk("drain_timeout", 64'(n), 64'(budget + 1));
   endtask

   // Requester driver and behavioural core, acting just after each active edge.
   initial begin : drv
      int idx;
      req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
      core_done = 1'b0; core_result = '0;
      for (int i = 0; i < N; i++) begin cur_a[i] = '0; cur_b[i] = '0; cur_lat[i] = 0; end
      forever begin
         @(posedge sys_clk); #1;
         for (int i = 0; i < N; i++) begin
            if (granted[i]) req_valid[i] = 1'b0;
            if (!req_valid[i]) begin
               idx = -1;
               for (int k = 0; k < jobs.size(); k++)
                  if (idx < 0 && jobs[k].id == i) idx = k;
               if (idx >= 0) begin
                  cur_a[i]   = jobs[idx].a;
                  cur_b[i]   = jobs[idx].b;
                  cur_lat[i] = jobs[idx].lat;
                  req_a[i*DW +: DW] = jobs[idx].a;
                  req_b[i*DW +: DW] = jobs[idx].b;
                  req_valid[i] = 1'b1;
                  jobs.delete(idx);
               end
            end
         end
         granted = '0;
         core_done = core_pend && (cyc == done_at);
         core_result = core_done ? core_res : DW'($urandom);
         if (core_done) core_pend = 1'b0;
         resp_ready = bp_low ? 1'b0 : (rnd_ready ? ($urandom_range(3) != 0) : 1'b1);
      end
   end

   // Monitor: predicts grants and responses, checks everything the DUT presents.
   initial begin : mon
      int            w;
      int            best;
      int            d;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      int unsigned   lat;
      resp_t         e;
      core_t         c;
      logic          prev_rv;
      logic [IW-1:0] cap_id;
      logic [DW-1:0] cap_data;
      logic          cap_err;
      logic [N-1:0]  hs;
      prev_rv = 1'b0; cap_id = '0; cap_data = '0; cap_err = 1'b0;
      forever begin
         @(negedge sys_clk);
         if (!chk_en) begin
            prev_rv = 1'b0;
         end else begin
            hs = req_valid & req_ready;
            if (req_ready != '0) begin
               w = -1;
               best = N;
               for (int j = 0; j < N; j++) begin
                  d = (j + N - model_rr) % N;
                  if (req_valid[j] && d < best) begin best = d; w = j; end
               end
               chk("req_ready", 64'(req_ready), (w < 0) ? 64'd0 : (64'd1 << w));
               for (int j = 0; j < N; j++) if (hs[j]) gl.push_back(j);
               granted = hs;
               if (w >= 0) begin
                  a = cur_a[w]; b = cur_b[w]; lat = cur_lat[w];
                  e.id = w; e.err = 1'b0;
                  if (a == '0 || b == '0) begin
                     e.data = a | b;
                     e.cyc  = cyc + 1;
                  end else begin
                     c.a = a; c.b = b; c.lat = lat; c.cyc = cyc + 1;
                     core_q.push_back(c);
                     n_start_exp++;
                     if (lat != 0 && lat <= TO) begin
                        e.data = gcd(a, b);
                        e.cyc  = cyc + 2 + lat;
                     end else begin
                        e.data = '0;
                        e.err  = 1'b1;
                        e.cyc  = cyc + TO + 3;
                        abort_q.push_back(cyc + TO + 2);
                     end
                  end
                  exp_q.push_back(e);
                  model_rr = (w + 1) % N;
               end
            end
            if (resp_valid) begin
               if (!prev_rv) begin
                  if (exp_q.size() == 0) begin
                     chk("resp_unexpected", 64'(resp_data), 64'hdead);
                  end else begin
                     e = exp_q.pop_front();
                     chk("resp_id", 64'(resp_id), 64'(e.id));
                     chk("resp_data", 64'(resp_data), 64'(e.data));
                     chk("resp_err", 64'(resp_err), 64'(e.err));
                     chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                  end
                  cap_id = resp_id; cap_data = resp_data; cap_err = resp_err;
               end else begin
                  chk("resp_hold", {29'd0, resp_id, resp_data, resp_err},
                      {29'd0, cap_id, cap_data, cap_err});
               end
               chk("busy_in_resp", 64'(busy), 64'd1);
               chk("ready_while_busy", 64'(req_ready), 64'd0);
            end
            prev_rv = resp_valid;
            if (core_start) begin
               n_start++;
               if (core_q.size() == 0) begin
                  chk("core_start_unexpected", 64'(core_a), 64'hdead);
               end else begin
                  c = core_q.pop_front();
                  chk("core_a", 64'(core_a), 64'(c.a));
                  chk("core_b", 64'(core_b), 64'(c.b));
                  chk("core_start_cycle", 64'(cyc), 64'(c.cyc));
                  core_pend = (c.lat != 0);
                  done_at   = cyc + c.lat;
                  core_res  = gcd(core_a, core_b);
               end
            end
            if (!core_rst_n) begin
               if (abort_q.size() == 0) chk("core_rst_unexpected", 64'(core_rst_n), 64'd1);
               else chk("abort_cycle", 64'(cyc), 64'(abort_q.pop_front()));
            end
         end
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int          rr_exp[5];
      int unsigned g;
      int unsigned r;
      int unsigned lat;
      int          n;
      logic [DW-1:0] ra;
      logic [DW-1:0] rb;
      rr_exp = '{0, 1, 2, 3, 0};
      sys_rst_n = 1'b0;
      repeat (3) @(negedge sys_clk);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_core_rst_n", 64'(core_rst_n), 64'd0);
      chk("rst_core_start", 64'(core_start), 64'd0);
      chk("rst_resp_fields", {29'd0, resp_id, resp_data, resp_err}, 64'd0);
      chk("rst_core_ops", {core_a, core_b}, 64'd0);
      @(posedge sys_clk); #1 sys_rst_n = 1'b1;
      @(posedge sys_clk); #1;
      chk("core_rst_release", 64'(core_rst_n), 64'd1);
      chk_en = 1'b1;

      // Basic core path, zero short-circuits, then leave rr at 0.
      post(0, 48, 18, 10);        wait_drain(200);
      post(2, 0, 35, 5);          wait_drain(200);
      post(2, 0, 0, 5);           wait_drain(200);
      post(3, 7, 0, 5);           wait_drain(200);

      // Round-robin with all requesters pending.
      gl.delete();
      post(0, 12, 8, 3); post(1, 21, 14, 2); post(2, 0, 9, 1); post(3, 27, 18, 4);
      post(0, 77, 0, 1);
      wait_drain(400);
      chk("rr_count", 64'(gl.size()), 64'd5);
      for (int k = 0; k < 5; k++) if (k < gl.size()) chk("rr_order", 64'(gl[k]), 64'(rr_exp[k]));

      // Hang, late done, done on the final timeout cycle, last in-time done, fastest done.
      post(1, 9, 6, 0);           wait_drain(200);
      post(1, 9, 6, 17);          wait_drain(200);
      post(2, 100, 75, 16);       wait_drain(200);
      post(3, 35, 21, 15);        wait_drain(200);
      post(0, 5, 3, 1);           wait_drain(200);

      // Response backpressure with another requester waiting.
      bp_low = 1'b1;
      post(0, 0, 4, 1); post(1, 0, 3, 1);
      n = 0;
      while (!resp_valid && n < 50) begin @(negedge sys_clk); #2; n++; end
      chk("bp_resp_seen", 64'(resp_valid), 64'd1);
      repeat (5) @(negedge sys_clk);
      #2 bp_low = 1'b0;
      wait_drain(200);

      // Randomized traffic.
      rnd_ready = 1'b1;
      for (int batch = 0; batch < 5; batch++) begin
         for (int k = 0; k < 8; k++) begin
            g  = $urandom_range(1, 40);
            ra = DW'(g * $urandom_range(0, 50));
            rb = DW'(g * $urandom_range(0, 50));
            if ($urandom_range(0, 5) == 0) ra = '0;
            r = $urandom_range(0, 9);
            lat = (r == 0) ? 0 : (r == 1) ? 17 : (r == 2) ? 16 : $urandom_range(1, 15);
            post(int'($urandom_range(0, 3)), ra, rb, lat);
         end
         wait_drain(3000);
      end
      rnd_ready = 1'b0;

      // Reset in the middle of WAIT drops the job; rr restarts at 0.
      post(1, 10, 4, 0);
      n = n_start;
      r = 0;
      while (n_start == n && r < 50) begin @(negedge sys_clk); #2; r++; end
      chk("mid_reset_launch", 64'(n_start), 64'(n + 1));
      repeat (4) @(negedge sys_clk);
      #2 sys_rst_n = 1'b0;
      #1;
      chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_core_rst_n", 64'(core_rst_n), 64'd0);
      chk_en = 1'b0;
      exp_q.delete(); core_q.delete(); abort_q.delete(); jobs.delete();
      core_pend = 1'b0; granted = '0; req_valid = '0; core_done = 1'b0;
      model_rr = 0;
      @(posedge sys_clk); #1 sys_rst_n = 1'b1;
      @(posedge sys_clk); #1;
      chk("mid_rst_core_release", 64'(core_rst_n), 64'd1);
      chk_en = 1'b1;
      gl.delete();
      post(3, 0, 6, 1); post(1, 0, 8, 1);
      wait_drain(200);
      chk("post_rst_grants", 64'(gl.size()), 64'd2);
      if (gl.size() > 0) chk("post_rst_first", 64'(gl[0]), 64'd1);

      chk("end_exp_empty", 64'(exp_q.size()), 64'd0);
      chk("end_core_q_empty", 64'(core_q.size()), 64'd0);
      chk("end_abort_q_empty", 64'(abort_q.size()), 64'd0);
      chk("core_start_total", 64'(n_start), 64'(n_start_exp));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
